// File: rtl/uart_cmd_handler.sv
// Command stage behind the UART receiver: decodes command words, runs sensor read
// handshakes (one-shot or continuous) and hands 16-bit responses to the transmitter.
module uart_cmd_handler #(
  parameter int NUM_SENSORS     = 32,
  parameter int SENSOR_TIMEOUT  = 4800,
  parameter int TX_FRAME_CYCLES = 22
) (
  input  logic        clk_9k6,
  input  logic        reset_n,
  input  logic [15:0] data_recevied,
  input  logic        data_ready_to_read,
  output logic        sensor_req,
  output logic [7:0]  sensor_addr,
  input  logic        sensor_ready,
  input  logic        sensor_error,
  input  logic [7:0]  sensor_temp,
  input  logic [7:0]  sensor_hum,
  output logic [15:0] data_to_send,
  output logic        enable_transmiter,
  output logic        overrun
);

  localparam int         CNT_W = $clog2(SENSOR_TIMEOUT + TX_FRAME_CYCLES + 1);
  localparam logic [8:0] NUM_S = 9'(NUM_SENSORS);

  typedef enum logic [2:0] {IDLE, DECODE, REQ, WAIT, SEND, TXWAIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             drr_p0;
  logic             rise;
  logic [15:0]      pend_word;
  logic             pend_vld;
  logic             take;
  logic [15:0]      cur_word;
  logic [7:0]       cmd, addr;
  logic [2:0]       kind;
  logic [7:0]       kind_addr;
  logic             cont;
  logic             load_target, set_cont, clr_cont;
  logic [15:0]      resp_nxt;

  // Read commands 1..4 map onto response codes 0x11..0x14; odd kinds read temperature.
  function automatic logic [15:0] read_word(input logic [2:0] k, input logic [7:0] t,
                                            input logic [7:0] h);
    return {5'b00010, k, (k[0] ? t : h)};
  endfunction

  assign rise              = data_ready_to_read & ~drr_p0;
  assign cmd               = cur_word[15:8];
  assign addr              = cur_word[7:0];
  assign sensor_req        = (state == REQ);
  assign enable_transmiter = (state == SEND);

  always_comb begin
    state_nxt   = state;
    resp_nxt    = data_to_send;
    take        = 1'b0;
    load_target = 1'b0;
    set_cont    = 1'b0;
    clr_cont    = 1'b0;
    cnt_nxt     = cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        if (pend_vld) begin
          state_nxt = DECODE;
          take      = 1'b1;
        end else if (cont) begin
          state_nxt = REQ;
        end
      end
      DECODE: begin
        state_nxt = SEND;
        if (cmd > 8'h05) begin
          resp_nxt = {8'hE0, cmd};
        end else if ({1'b0, addr} >= NUM_S) begin
          resp_nxt = {8'hE1, addr};
        end else if (cmd == 8'h00) begin
          resp_nxt = {8'h10, addr};
        end else if (cmd == 8'h05) begin
          resp_nxt = 16'h1500;
          clr_cont = 1'b1;
        end else begin
          state_nxt   = REQ;
          load_target = 1'b1;
          set_cont    = (cmd == 8'h03) || (cmd == 8'h04);
        end
      end
      REQ: state_nxt = WAIT;
      WAIT: begin
        // A ready pulse coinciding with the last timeout cycle is still a valid answer.
        if (sensor_ready) begin
          state_nxt = SEND;
          if (sensor_error) begin
            resp_nxt = {8'h1F, sensor_addr};
            clr_cont = 1'b1;
          end else begin
            resp_nxt = read_word(kind, sensor_temp, sensor_hum);
          end
        end else if (cnt == CNT_W'(SENSOR_TIMEOUT - 1)) begin
          state_nxt = SEND;
          resp_nxt  = {8'h1F, sensor_addr};
          clr_cont  = 1'b1;
        end
      end
      SEND: state_nxt = TXWAIT;
      TXWAIT: begin
        if (cnt == CNT_W'(TX_FRAME_CYCLES)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // The counter is zero in the REQ and SEND cycles, so it measures time since those.
    if (state_nxt == REQ || state_nxt == SEND) cnt_nxt = '0;
  end

  always_ff @(posedge clk_9k6 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      drr_p0       <= 1'b0;
      pend_word    <= '0;
      pend_vld     <= 1'b0;
      overrun      <= 1'b0;
      cur_word     <= '0;
      kind         <= '0;
      kind_addr    <= '0;
      cont         <= 1'b0;
      sensor_addr  <= '0;
      data_to_send <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      drr_p0 <= data_ready_to_read;
      if (rise) begin
        pend_word <= data_recevied;
        pend_vld  <= 1'b1;
        if (pend_vld && !take) overrun <= 1'b1;
      end else if (take) begin
        pend_vld <= 1'b0;
      end
      if (take) cur_word <= pend_word;
      if (load_target) begin
        kind      <= cmd[2:0];
        kind_addr <= addr;
      end
      if (set_cont) cont <= 1'b1;
      else if (clr_cont) cont <= 1'b0;
      if (state_nxt == REQ) sensor_addr <= load_target ? addr : kind_addr;
      if (state_nxt == SEND) data_to_send <= resp_nxt;
    end
  end

endmodule

// File: tb/tb_uart_cmd_handler.sv
// Self-checking bench for uart_cmd_handler: directed boundary cases plus randomized
// one-shot commands, all checked against a command-table reference model.
module tb_uart_cmd_handler;

  localparam int NS  = 32;
  localparam int TO  = 40;
  localparam int TXC = 22;

  logic        clk_9k6 = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] data_recevied = 16'h0000;
  logic        data_ready_to_read = 1'b0;
  logic        sensor_req;
  logic [7:0]  sensor_addr;
  logic        sensor_ready = 1'b0;
  logic        sensor_error = 1'b0;
  logic [7:0]  sensor_temp = 8'h00;
  logic [7:0]  sensor_hum = 8'h00;
  logic [15:0] data_to_send;
  logic        enable_transmiter;
  logic        overrun;

  uart_cmd_handler #(
    .NUM_SENSORS(NS), .SENSOR_TIMEOUT(TO), .TX_FRAME_CYCLES(TXC)
  ) dut (
    .clk_9k6(clk_9k6), .reset_n(reset_n),
    .data_recevied(data_recevied), .data_ready_to_read(data_ready_to_read),
    .sensor_req(sensor_req), .sensor_addr(sensor_addr),
    .sensor_ready(sensor_ready), .sensor_error(sensor_error),
    .sensor_temp(sensor_temp), .sensor_hum(sensor_hum),
    .data_to_send(data_to_send), .enable_transmiter(enable_transmiter),
    .overrun(overrun)
  );

  always #5 clk_9k6 = ~clk_9k6;

  int cyc = 0;
  always @(posedge clk_9k6) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", tag, got, exp);
  endtask

  // Event log of what the DUT put on its output handshakes.
  int          req_cyc[$];
  logic [7:0]  req_addr_q[$];
  int          tx_cyc[$];
  logic [15:0] tx_dat[$];
  always @(negedge clk_9k6) begin
    if (sensor_req) begin
      req_cyc.push_back(cyc);
      req_addr_q.push_back(sensor_addr);
    end
    if (enable_transmiter) begin
      tx_cyc.push_back(cyc);
      tx_dat.push_back(data_to_send);
    end
  end

  // Sensor front-end model: answers each request after ans_delay cycles (-1 = never).
  int         ans_delay = 1;
  bit         ans_err = 1'b0;
  int         temp_base = 0;
  int         hum_base = 0;
  int         ans_n = 0;
  int         stray_cnt = 0;
  int         stray_done = 0;
  int         ans_cyc[$];
  logic [7:0] ans_t[$];
  logic [7:0] ans_h[$];
  bit         ans_e[$];
  initial begin
    forever begin
      @(negedge clk_9k6);
      if (stray_cnt != stray_done) begin
        stray_done = stray_done + 1;
        @(posedge clk_9k6);
        #1 sensor_ready = 1'b1;
        sensor_temp = 8'hAA;
        @(posedge clk_9k6);
        #1 sensor_ready = 1'b0;
      end else if (sensor_req && ans_delay >= 0) begin
        repeat (ans_delay) @(posedge clk_9k6);
        #1;
        sensor_temp  = 8'(temp_base + ans_n);
        sensor_hum   = 8'(hum_base + ans_n);
        sensor_error = ans_err;
        sensor_ready = 1'b1;
        ans_cyc.push_back(cyc);
        ans_t.push_back(sensor_temp);
        ans_h.push_back(sensor_hum);
        ans_e.push_back(ans_err);
        ans_n = ans_n + 1;
        @(posedge clk_9k6);
        #1 sensor_ready = 1'b0;
        sensor_error = 1'b0;
      end
    end
  end

  // Reference model: response table for a command word.
  function automatic logic [15:0] decode_resp(input logic [15:0] w, output bit rd);
    logic [7:0] c;
    logic [7:0] a;
    c  = w[15:8];
    a  = w[7:0];
    rd = 1'b0;
    if (c > 8'h05) return {8'hE0, c};
    if (int'(a) >= NS) return {8'hE1, a};
    if (c == 8'h00) return {8'h10, a};
    if (c == 8'h05) return 16'h1500;
    rd = 1'b1;
    return 16'h0000;
  endfunction

  function automatic logic [15:0] read_resp(input logic [7:0] c, input logic [7:0] a,
                                            input logic [7:0] t, input logic [7:0] h,
                                            input bit e);
    if (e) return {8'h1F, a};
    if (c == 8'h01 || c == 8'h03) return {8'(8'h10 + c), t};
    return {8'(8'h10 + c), h};
  endfunction

  task automatic send_word(input logic [15:0] w, output int n);
    @(posedge clk_9k6);
    #1;
    data_recevied      = w;
    data_ready_to_read = 1'b1;
    n                  = cyc;
    @(posedge clk_9k6);
    #1 data_ready_to_read = 1'b0;
  endtask

  task automatic wait_tx(input int want, input int budget, input string tag);
    int k;
    k = 0;
    while (tx_cyc.size() < want && k < budget) begin
      @(posedge clk_9k6);
      k++;
    end
    if (tx_cyc.size() < want) chk(tag, tx_cyc.size(), want);
  endtask

  task automatic run_single(input logic [15:0] w, input int delay, input bit err,
                            input string tag);
    int n, r0, t0, a0, exp_cyc;
    bit rd;
    logic [15:0] exp_w;
    r0 = req_cyc.size();
    t0 = tx_cyc.size();
    a0 = ans_cyc.size();
    ans_delay = delay;
    ans_err   = err;
    exp_w = decode_resp(w, rd);
    send_word(w, n);
    wait_tx(t0 + 1, TO + 20, {tag, " tx_timeout"});
    repeat (TXC + 6) @(posedge clk_9k6);
    #1;
    chk({tag, " tx_count"}, tx_cyc.size() - t0, 1);
    if (!rd) begin
      chk({tag, " req_count"}, req_cyc.size() - r0, 0);
      exp_cyc = n + 3;
    end else begin
      chk({tag, " req_count"}, req_cyc.size() - r0, 1);
      chk({tag, " req_cycle"}, req_cyc[r0], n + 3);
      chk({tag, " req_addr"}, req_addr_q[r0], w[7:0]);
      if (delay >= 0 && delay < TO) begin
        exp_cyc = ans_cyc[a0] + 1;
        exp_w   = read_resp(w[15:8], w[7:0], ans_t[a0], ans_h[a0], ans_e[a0]);
      end else begin
        exp_cyc = req_cyc[r0] + TO;
        exp_w   = {8'h1F, w[7:0]};
      end
    end
    chk({tag, " tx_cycle"}, tx_cyc[t0], exp_cyc);
    chk({tag, " tx_word"}, tx_dat[t0], exp_w);
    chk({tag, " held_word"}, data_to_send, exp_w);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int n, t0, r0, r1, a0, sel, dly, k;
    logic [7:0] c, a;
    logic [15:0] last_w;
    bit e;

    repeat (3) @(posedge clk_9k6);
    #1;
    chk("rst sensor_req", sensor_req, 0);
    chk("rst sensor_addr", sensor_addr, 0);
    chk("rst data_to_send", data_to_send, 0);
    chk("rst enable_transmiter", enable_transmiter, 0);
    chk("rst overrun", overrun, 0);
    reset_n = 1'b1;

    temp_base = 'h19 - ans_n;
    run_single(16'h0105, 3, 1'b0, "rd_temp");
    chk("rd_temp const", tx_dat[tx_dat.size() - 1], 16'h1119);
    run_single(16'h0920, 2, 1'b0, "bad_cmd");
    chk("bad_cmd const", tx_dat[tx_dat.size() - 1], 16'hE009);
    run_single(16'h0140, 2, 1'b0, "bad_addr");
    chk("bad_addr const", tx_dat[tx_dat.size() - 1], 16'hE140);
    run_single(16'h0203, -1, 1'b0, "timeout");
    chk("timeout const", tx_dat[tx_dat.size() - 1], 16'h1F03);
    run_single(16'h021F, TO - 1, 1'b0, "ready_at_timeout");
    run_single(16'h0106, TO + 2, 1'b0, "late_ready");
    run_single(16'h0208, 4, 1'b1, "sensor_err");
    run_single(16'h000C, 2, 1'b0, "status");

    t0 = tx_cyc.size();
    r0 = req_cyc.size();
    stray_cnt = stray_cnt + 1;
    repeat (10) @(posedge clk_9k6);
    #1;
    chk("stray tx_count", tx_cyc.size() - t0, 0);
    chk("stray req_count", req_cyc.size() - r0, 0);

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) c = 8'h00;
      else if (sel < 5) c = 8'h01;
      else if (sel < 8) c = 8'h02;
      else if (sel == 8) c = 8'h05;
      else c = 8'($urandom_range(6, 255));
      a   = 8'($urandom_range(0, 40));
      dly = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(1, 8);
      e   = ($urandom_range(0, 5) == 0);
      temp_base = $urandom_range(0, 255);
      hum_base  = $urandom_range(0, 255);
      run_single({c, a}, dly, e, "rnd");
    end

    // Continuous temperature on sensor 2, then stop.
    t0 = tx_cyc.size();
    r0 = req_cyc.size();
    ans_delay = 2;
    ans_err   = 1'b0;
    temp_base = 20 - ans_n;
    send_word(16'h0302, n);
    wait_tx(t0 + 3, 3 * (TO + TXC + 10), "cont tx_timeout");
    send_word(16'h0500, n);
    k = 0;
    while (!(tx_dat.size() > t0 && tx_dat[tx_dat.size() - 1] === 16'h1500) &&
           k < 4 * (TO + TXC)) begin
      @(posedge clk_9k6);
      k++;
    end
    #1;
    r1 = req_cyc.size();
    repeat (2 * (TO + TXC)) @(posedge clk_9k6);
    #1;
    chk("cont stop no_req", req_cyc.size() - r1, 0);
    chk("cont last_word", tx_dat[tx_dat.size() - 1], 16'h1500);
    chk("cont req_addr", req_addr_q[r0], 8'h02);
    for (int i = 0; i < 3; i++) chk("cont word", tx_dat[t0 + i], {8'h13, 8'(20 + i)});
    for (int i = t0 + 1; i < tx_cyc.size(); i++)
      chk("cont spacing", (tx_cyc[i] - tx_cyc[i - 1]) >= TXC + 1, 1);
    for (int i = t0 + 3; i < tx_dat.size() - 1; i++) begin
      last_w = tx_dat[i];
      chk("cont extra_code", last_w[15:8], 8'h13);
    end

    // Three command words while a read is outstanding.
    chk("ovr pre", overrun, 0);
    t0 = tx_cyc.size();
    r0 = req_cyc.size();
    ans_delay = 15;
    temp_base = 'h33 - ans_n;
    send_word(16'h0107, n);
    k = 0;
    while (req_cyc.size() == r0 && k < 20) begin
      @(posedge clk_9k6);
      k++;
    end
    send_word(16'h0011, n);
    send_word(16'h0012, n);
    send_word(16'h0013, n);
    wait_tx(t0 + 2, TO + 2 * TXC + 20, "ovr tx_timeout");
    repeat (TXC + 6) @(posedge clk_9k6);
    #1;
    chk("ovr flag", overrun, 1);
    chk("ovr tx_count", tx_cyc.size() - t0, 2);
    chk("ovr req_count", req_cyc.size() - r0, 1);
    chk("ovr first", tx_dat[t0], 16'h1133);
    chk("ovr last", tx_dat[t0 + 1], 16'h1013);

    // Asynchronous reset during TXWAIT of continuous humidity.
    t0 = tx_cyc.size();
    ans_delay = 2;
    hum_base  = 'h40 - ans_n;
    send_word(16'h0401, n);
    wait_tx(t0 + 1, TO + 20, "rst_cont tx_timeout");
    repeat (5) @(posedge clk_9k6);
    #2 reset_n = 1'b0;
    #1;
    chk("arst sensor_req", sensor_req, 0);
    chk("arst sensor_addr", sensor_addr, 0);
    chk("arst data_to_send", data_to_send, 0);
    chk("arst enable_transmiter", enable_transmiter, 0);
    chk("arst overrun", overrun, 0);
    repeat (3) @(posedge clk_9k6);
    #1 reset_n = 1'b1;
    r1 = req_cyc.size();
    t0 = tx_cyc.size();
    repeat (2 * (TO + TXC)) @(posedge clk_9k6);
    #1;
    chk("arst no_req", req_cyc.size() - r1, 0);
    chk("arst no_tx", tx_cyc.size() - t0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
